// File: rtl/fsa_pkg.sv
// Shared types and default parameters for the fiber-header frame-rate filter.
package fsa_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FILL  = 1'b1
    } ch_state_e;

    localparam int unsigned IMG_WW_DEF     = 12;
    localparam int unsigned AVG_LOG2_DEF   = 2;
    localparam int unsigned JITTER_TOL_DEF = 4;
    localparam int unsigned MISS_W_DEF     = 8;

endpackage

// File: rtl/fsa_header_avg.sv
// One header channel: batches 2^C_AVG_LOG2 consistent X samples, publishes their
// floor average, and tracks total and consecutive misses.
module fsa_header_avg
    import fsa_pkg::*;
#(
    parameter int unsigned C_IMG_WW     = IMG_WW_DEF,
    parameter int unsigned C_AVG_LOG2   = AVG_LOG2_DEF,
    parameter int unsigned C_JITTER_TOL = JITTER_TOL_DEF,
    parameter int unsigned C_MISS_W     = MISS_W_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                sample_i,
    input  logic                flush_i,
    input  logic                hdr_valid_i,
    input  logic [C_IMG_WW-1:0] hdr_x_i,
    output logic                out_valid_o,
    output logic [C_IMG_WW-1:0] out_x_o,
    output logic [C_MISS_W-1:0] miss_cnt_o,
    output logic                publish_c
);

    localparam int unsigned ACC_W  = C_IMG_WW + C_AVG_LOG2;
    localparam int unsigned CNT_W  = C_AVG_LOG2 + 1;
    localparam int unsigned DIFF_W = C_IMG_WW + 1;
    localparam logic [CNT_W-1:0]  BATCH_CNT = CNT_W'(1 << C_AVG_LOG2);
    localparam logic [DIFF_W-1:0] TOL       = DIFF_W'(C_JITTER_TOL);

    ch_state_e           state_q, state_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [C_IMG_WW-1:0] ref_q, ref_d;
    logic [CNT_W-1:0]    cmiss_q, cmiss_d;
    logic                valid_q, valid_d;
    logic [C_IMG_WW-1:0] x_q, x_d;
    logic [C_MISS_W-1:0] miss_q, miss_d;

    logic [DIFF_W-1:0]   diff;
    logic [DIFF_W-1:0]   abs_diff;
    logic                in_tol;

    // Deviation from the batch's first sample, widened by one bit so it never wraps.
    always_comb begin
        diff     = {1'b0, hdr_x_i} - {1'b0, ref_q};
        abs_diff = diff[DIFF_W-1] ? (~diff + DIFF_W'(1)) : diff;
        in_tol   = (abs_diff <= TOL);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= EMPTY;
            acc_q   <= '0;
            cnt_q   <= '0;
            ref_q   <= '0;
            cmiss_q <= '0;
            valid_q <= 1'b0;
            x_q     <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ref_q   <= ref_d;
            cmiss_q <= cmiss_d;
            valid_q <= valid_d;
            x_q     <= x_d;
            miss_q  <= miss_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ref_d     = ref_q;
        cmiss_d   = cmiss_q;
        valid_d   = valid_q;
        x_d       = x_q;
        miss_d    = miss_q;
        publish_c = 1'b0;

        if (flush_i) begin
            state_d = EMPTY;
            acc_d   = '0;
            cnt_d   = '0;
        end else if (sample_i) begin
            if (hdr_valid_i) begin
                if (state_q == FILL && in_tol) begin
                    acc_d = acc_q + ACC_W'(hdr_x_i);
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    acc_d = ACC_W'(hdr_x_i);
                    ref_d = hdr_x_i;
                    cnt_d = CNT_W'(1);
                end
                if (state_q == EMPTY) begin
                    cmiss_d = '0;
                end
                state_d = FILL;
                // Full batch: publish the floor average and start over.
                if (cnt_d == BATCH_CNT) begin
                    publish_c = 1'b1;
                    x_d       = C_IMG_WW'(acc_d >> C_AVG_LOG2);
                    valid_d   = 1'b1;
                    state_d   = EMPTY;
                    acc_d     = '0;
                    cnt_d     = '0;
                end
            end else begin
                state_d = EMPTY;
                acc_d   = '0;
                cnt_d   = '0;
                if (miss_q != '1) begin
                    miss_d = miss_q + C_MISS_W'(1);
                end
                if (cmiss_q != '1) begin
                    cmiss_d = cmiss_q + CNT_W'(1);
                end
                if (cmiss_d >= BATCH_CNT) begin
                    valid_d = 1'b0;
                end
            end
        end
    end

    assign out_valid_o = valid_q;
    assign out_x_o     = x_q;
    assign miss_cnt_o  = miss_q;

endmodule

// File: rtl/fsa_header_filter.sv
// Frame-rate header filter: two independent averaging channels gated by the
// software enable, with a shared registered update pulse.
module fsa_header_filter
    import fsa_pkg::*;
#(
    parameter int unsigned C_IMG_WW     = IMG_WW_DEF,
    parameter int unsigned C_AVG_LOG2   = AVG_LOG2_DEF,
    parameter int unsigned C_JITTER_TOL = JITTER_TOL_DEF,
    parameter int unsigned C_MISS_W     = MISS_W_DEF
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                en,
    input  logic                frame_done,
    input  logic                lft_header_valid_i,
    input  logic [C_IMG_WW-1:0] lft_header_x_i,
    input  logic                rt_header_valid_i,
    input  logic [C_IMG_WW-1:0] rt_header_x_i,
    output logic                lft_valid,
    output logic [C_IMG_WW-1:0] lft_x,
    output logic                rt_valid,
    output logic [C_IMG_WW-1:0] rt_x,
    output logic                update,
    output logic [C_MISS_W-1:0] lft_miss_cnt,
    output logic [C_MISS_W-1:0] rt_miss_cnt
);

    logic sample;
    logic flush;
    logic lft_pub_c;
    logic rt_pub_c;
    logic update_q;

    assign sample = en & frame_done;
    assign flush  = ~en;

    fsa_header_avg #(
        .C_IMG_WW    (C_IMG_WW),
        .C_AVG_LOG2  (C_AVG_LOG2),
        .C_JITTER_TOL(C_JITTER_TOL),
        .C_MISS_W    (C_MISS_W)
    ) u_lft (
        .clk        (clk),
        .resetn     (resetn),
        .sample_i   (sample),
        .flush_i    (flush),
        .hdr_valid_i(lft_header_valid_i),
        .hdr_x_i    (lft_header_x_i),
        .out_valid_o(lft_valid),
        .out_x_o    (lft_x),
        .miss_cnt_o (lft_miss_cnt),
        .publish_c  (lft_pub_c)
    );

    fsa_header_avg #(
        .C_IMG_WW    (C_IMG_WW),
        .C_AVG_LOG2  (C_AVG_LOG2),
        .C_JITTER_TOL(C_JITTER_TOL),
        .C_MISS_W    (C_MISS_W)
    ) u_rt (
        .clk        (clk),
        .resetn     (resetn),
        .sample_i   (sample),
        .flush_i    (flush),
        .hdr_valid_i(rt_header_valid_i),
        .hdr_x_i    (rt_header_x_i),
        .out_valid_o(rt_valid),
        .out_x_o    (rt_x),
        .miss_cnt_o (rt_miss_cnt),
        .publish_c  (rt_pub_c)
    );

    // Update is registered alongside the published X values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            update_q <= 1'b0;
        end else begin
            update_q <= lft_pub_c | rt_pub_c;
        end
    end

    assign update = update_q;

endmodule

// File: tb/tb_fsa_header_filter.sv
// Bench for fsa_header_filter: directed vector table, hand sequences for the
// multi-cycle corners, and randomized traffic against a batch-level model.
module tb_fsa_header_filter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        en;
    logic        frame_done;
    logic        lft_header_valid_i;
    logic [11:0] lft_header_x_i;
    logic        rt_header_valid_i;
    logic [11:0] rt_header_x_i;
    logic        lft_valid;
    logic [11:0] lft_x;
    logic        rt_valid;
    logic [11:0] rt_x;
    logic        update;
    logic [7:0]  lft_miss_cnt;
    logic [7:0]  rt_miss_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: per side (0=left, 1=right) the running batch and published state.
    int m_sum[2];
    int m_cnt[2];
    int m_ref[2];
    int m_miss[2];
    int m_cons[2];
    int m_x[2];
    int m_v[2];
    int m_upd;

    typedef struct {
        int en; int fd;
        int lv; int lx; int rv; int rx;
        int e_lv; int e_lx; int e_rv; int e_rx; int e_upd; int e_lm; int e_rm;
    } vec_t;

    vec_t tbl[11];

    fsa_header_filter dut (
        .clk               (clk),
        .resetn            (resetn),
        .en                (en),
        .frame_done        (frame_done),
        .lft_header_valid_i(lft_header_valid_i),
        .lft_header_x_i    (lft_header_x_i),
        .rt_header_valid_i (rt_header_valid_i),
        .rt_header_x_i     (rt_header_x_i),
        .lft_valid         (lft_valid),
        .lft_x             (lft_x),
        .rt_valid          (rt_valid),
        .rt_x              (rt_x),
        .update            (update),
        .lft_miss_cnt      (lft_miss_cnt),
        .rt_miss_cnt       (rt_miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++) begin
            m_sum[s] = 0; m_cnt[s] = 0; m_ref[s] = 0;
            m_miss[s] = 0; m_cons[s] = 0; m_x[s] = 0; m_v[s] = 0;
        end
        m_upd = 0;
    endtask

    task automatic model_side(input int s, input int v, input int x);
        int d;
        if (v != 0) begin
            d = x - m_ref[s];
            if (d < 0) d = -d;
            if (m_cnt[s] == 0) m_cons[s] = 0;
            if (m_cnt[s] > 0 && d <= 4) begin
                m_sum[s] += x;
                m_cnt[s] += 1;
            end else begin
                m_sum[s] = x;
                m_ref[s] = x;
                m_cnt[s] = 1;
            end
            if (m_cnt[s] == 4) begin
                m_x[s]   = m_sum[s] / 4;
                m_v[s]   = 1;
                m_upd    = 1;
                m_sum[s] = 0;
                m_cnt[s] = 0;
            end
        end else begin
            m_sum[s] = 0;
            m_cnt[s] = 0;
            if (m_miss[s] < 255) m_miss[s]++;
            if (m_cons[s] < 7) m_cons[s]++;
            if (m_cons[s] >= 4) m_v[s] = 0;
        end
    endtask

    task automatic model_step(input int e, input int f, input int lv, input int lx,
                              input int rv, input int rx);
        m_upd = 0;
        if (e == 0) begin
            for (int s = 0; s < 2; s++) begin
                m_sum[s] = 0;
                m_cnt[s] = 0;
            end
        end else if (f != 0) begin
            model_side(0, lv, lx);
            model_side(1, rv, rx);
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then advance the model.
    task automatic step(input int e, input int f, input int lv, input int lx,
                        input int rv, input int rx);
        en                 = e[0];
        frame_done         = f[0];
        lft_header_valid_i = lv[0];
        lft_header_x_i     = 12'(lx);
        rt_header_valid_i  = rv[0];
        rt_header_x_i      = 12'(rx);
        @(posedge clk);
        #1;
        model_step(e, f, lv, lx, rv, rx);
    endtask

    task automatic check_model(input string tag);
        chk({tag, " lft_valid"}, int'(lft_valid), m_v[0]);
        chk({tag, " lft_x"}, int'(lft_x), m_x[0]);
        chk({tag, " rt_valid"}, int'(rt_valid), m_v[1]);
        chk({tag, " rt_x"}, int'(rt_x), m_x[1]);
        chk({tag, " update"}, int'(update), m_upd);
        chk({tag, " lft_miss"}, int'(lft_miss_cnt), m_miss[0]);
        chk({tag, " rt_miss"}, int'(rt_miss_cnt), m_miss[1]);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        en = 1'b0; frame_done = 1'b0;
        lft_header_valid_i = 1'b0; lft_header_x_i = '0;
        rt_header_valid_i = 1'b0; rt_header_x_i = '0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        model_reset();
    endtask

    initial begin
        int base[2];
        int xs[2];
        int vs[2];
        int e;
        int f;

        // {en, fd, lv, lx, rv, rx, exp lv, lx, rv, rx, upd, lmiss, rmiss}
        tbl[0]  = '{1, 1, 1, 100, 0, 0, 0, 0,   0, 0, 0, 0, 1};
        tbl[1]  = '{1, 1, 1, 102, 0, 0, 0, 0,   0, 0, 0, 0, 2};
        tbl[2]  = '{1, 1, 1, 101, 0, 0, 0, 0,   0, 0, 0, 0, 3};
        tbl[3]  = '{1, 1, 1, 103, 0, 0, 1, 101, 0, 0, 1, 0, 4};
        tbl[4]  = '{1, 0, 1, 103, 0, 0, 1, 101, 0, 0, 0, 0, 4};
        tbl[5]  = '{1, 1, 1, 100, 0, 0, 1, 101, 0, 0, 0, 0, 5};
        tbl[6]  = '{1, 1, 1, 100, 0, 0, 1, 101, 0, 0, 0, 0, 6};
        tbl[7]  = '{1, 1, 1, 110, 0, 0, 1, 101, 0, 0, 0, 0, 7};
        tbl[8]  = '{1, 1, 1, 111, 0, 0, 1, 101, 0, 0, 0, 0, 8};
        tbl[9]  = '{1, 1, 1, 109, 0, 0, 1, 101, 0, 0, 0, 0, 9};
        tbl[10] = '{1, 1, 1, 110, 0, 0, 1, 110, 0, 0, 1, 0, 10};

        do_reset();
        #1;
        chk("reset lft_valid", int'(lft_valid), 0);
        chk("reset lft_x", int'(lft_x), 0);
        chk("reset rt_valid", int'(rt_valid), 0);
        chk("reset update", int'(update), 0);
        chk("reset lft_miss", int'(lft_miss_cnt), 0);
        chk("reset rt_miss", int'(rt_miss_cnt), 0);

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].en, tbl[i].fd, tbl[i].lv, tbl[i].lx, tbl[i].rv, tbl[i].rx);
            chk($sformatf("tbl%0d lft_valid", i), int'(lft_valid), tbl[i].e_lv);
            chk($sformatf("tbl%0d lft_x", i), int'(lft_x), tbl[i].e_lx);
            chk($sformatf("tbl%0d rt_valid", i), int'(rt_valid), tbl[i].e_rv);
            chk($sformatf("tbl%0d rt_x", i), int'(rt_x), tbl[i].e_rx);
            chk($sformatf("tbl%0d update", i), int'(update), tbl[i].e_upd);
            chk($sformatf("tbl%0d lft_miss", i), int'(lft_miss_cnt), tbl[i].e_lm);
            chk($sformatf("tbl%0d rt_miss", i), int'(rt_miss_cnt), tbl[i].e_rm);
        end
        step(1, 0, 0, 0, 0, 0);
        chk("tbl update one cycle", int'(update), 0);

        // Right publishes 500, then four consecutive misses drop valid but hold X.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 1, 500);
        chk("rt pub valid", int'(rt_valid), 1);
        chk("rt pub x", int'(rt_x), 500);
        chk("rt pub update", int'(update), 1);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0);
        chk("rt 3 miss valid", int'(rt_valid), 1);
        step(1, 1, 0, 0, 0, 0);
        chk("rt 4 miss valid", int'(rt_valid), 0);
        chk("rt 4 miss x", int'(rt_x), 500);
        chk("rt 4 miss cnt", int'(rt_miss_cnt), 4);

        // Left miss counter saturates.
        do_reset();
        for (int i = 0; i < 300; i++) step(1, 1, 0, 0, 1, 7);
        chk("lft miss sat", int'(lft_miss_cnt), 255);
        chk("rt miss none", int'(rt_miss_cnt), 0);

        // Disabled frames are ignored; disabling mid-batch discards it.
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 1, 1, 100, 0, 0);
        chk("en0 lft_valid", int'(lft_valid), 0);
        chk("en0 update", int'(update), 0);
        chk("en0 rt_miss", int'(rt_miss_cnt), 0);
        step(1, 1, 1, 200, 1, 200);
        step(1, 1, 1, 200, 1, 200);
        step(0, 0, 1, 200, 1, 200);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 200, 1, 200);
        chk("en flush lft_valid", int'(lft_valid), 0);
        chk("en flush update", int'(update), 0);
        step(1, 1, 1, 200, 1, 200);
        chk("en refill lft_valid", int'(lft_valid), 1);
        chk("en refill lft_x", int'(lft_x), 200);
        chk("en refill rt_x", int'(rt_x), 200);

        // Asynchronous reset between edges clears everything immediately.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, 1, 300, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 300, 0, 0);
        en = 1'b1; frame_done = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        chk("async lft_valid", int'(lft_valid), 0);
        chk("async lft_x", int'(lft_x), 0);
        chk("async rt_miss", int'(rt_miss_cnt), 0);
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        step(1, 1, 1, 300, 0, 0);
        chk("post rst one sample", int'(lft_valid), 0);
        chk("post rst update", int'(update), 0);
        for (int i = 0; i < 3; i++) step(1, 1, 1, 300, 0, 0);
        chk("post rst publish", int'(lft_valid), 1);
        chk("post rst x", int'(lft_x), 300);

        // Randomized traffic compared every cycle against the model.
        do_reset();
        base[0] = 1000; base[1] = 3000;
        for (int i = 0; i < 3000; i++) begin
            for (int s = 0; s < 2; s++) begin
                if ($urandom_range(0, 15) == 0) begin
                    case ($urandom_range(0, 2))
                        0: base[s] = int'($urandom_range(0, 20));
                        1: base[s] = int'($urandom_range(4075, 4095));
                        default: base[s] = int'($urandom_range(0, 4095));
                    endcase
                end
                xs[s] = base[s] + int'($urandom_range(0, 12)) - 6;
                if (xs[s] < 0) xs[s] = 0;
                if (xs[s] > 4095) xs[s] = 4095;
                vs[s] = ($urandom_range(0, 99) < 85) ? 1 : 0;
            end
            e = ($urandom_range(0, 99) < 95) ? 1 : 0;
            f = ($urandom_range(0, 99) < 60) ? 1 : 0;
            step(e, f, vs[0], xs[0], vs[1], xs[1]);
            check_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsa_header_filter.md
# fsa_header_filter

Frame-rate filter for the fiber-header detector outputs. It samples the per-frame left and right header results at each frame-done strobe. It averages 2^C_AVG_LOG2 mutually consistent frames per side and publishes stable header X positions, with valid flags and miss statistics, to the register/overlay side. It sits directly downstream of the header-detection stage and upstream of the CSR block.

## Interface
Parameters:
- C_IMG_WW, 12, width of X coordinates.
- C_AVG_LOG2, 2, log2 of frames averaged per published result (4 frames).
- C_JITTER_TOL, 4, maximum absolute X deviation from the first frame of a batch.
- C_MISS_W, 8, width of the saturating miss counters.

Ports:
- clk, in, 1, pixel clock.
- resetn, in, 1, reset. Asynchronous, active-low. Every register clears on assertion.
- en, in, 1, software enable.
- frame_done, in, 1, one-cycle strobe after the analysis region, before the detector clears its results.
- lft_header_valid_i, in, 1, detector left result valid.
- lft_header_x_i, in, C_IMG_WW, detector left X.
- rt_header_valid_i, in, 1, detector right result valid.
- rt_header_x_i, in, C_IMG_WW, detector right X.
- lft_valid, out, 1, published left result valid.
- lft_x, out, C_IMG_WW, published left X.
- rt_valid, out, 1, published right result valid.
- rt_x, out, C_IMG_WW, published right X.
- update, out, 1, one-cycle pulse when either side publishes.
- lft_miss_cnt, out, C_MISS_W, saturating count of left frames without a header.
- rt_miss_cnt, out, C_MISS_W, saturating count of right frames without a header.

## Operation
- Each side is an independent channel. A channel holds:
  - state: EMPTY or FILL.
  - acc: C_IMG_WW+C_AVG_LOG2 bits.
  - cnt: C_AVG_LOG2+1 bits.
  - ref_x.
  - consec_miss: C_AVG_LOG2+1 bits, saturating.
- A sample event is frame_done=1 with en=1. With en=0, frame_done is ignored.
- Sample with header valid, in EMPTY: acc=x, ref_x=x, cnt=1, next state FILL. Clear consec_miss.
- Sample with header valid, in FILL:
  - If |x−ref_x| ≤ C_JITTER_TOL: acc+=x, cnt+=1.
  - Otherwise the batch restarts: acc=x, ref_x=x, cnt=1, state stays FILL.
  - |x−ref_x| is computed in C_IMG_WW+1 bits, signed, with no wrap.
- When the updated cnt equals 2^C_AVG_LOG2, the channel publishes:
  - out_x = acc_new >> C_AVG_LOG2 (floor).
  - out_valid=1.
  - state returns to EMPTY; cnt and acc clear.
- Sample with header invalid:
  - acc and cnt clear; state goes to EMPTY.
  - miss_cnt increments, saturating at all-ones.
  - consec_miss increments, saturating.
  - When consec_miss reaches 2^C_AVG_LOG2, out_valid clears. out_x holds its last value.
- update = OR of both channel publish events, registered together with out_x.
- en deassert: on the next cycle both channels go to EMPTY and acc/cnt clear. Published outputs and miss counters hold.
- The 2^C_AVG_LOG2-sample sum fits acc by construction. No overflow handling is required.

## Timing
- frame_done at cycle t → channel state, out_x/out_valid, miss counters and update all change at t+1. update is high for exactly one cycle.
- frame_done on consecutive cycles: each one is a separate sample event. No back-pressure.
- en and frame_done in the same cycle: en is sampled that cycle.
- Reset values:
  - lft_valid=rt_valid=0, lft_x=rt_x=0.
  - update=0, miss counters=0.
  - Channels EMPTY with acc=cnt=consec_miss=0.
- resetn asserted mid-batch: partial accumulation is discarded. The first sample after release starts a new batch.

## Structure
- Shared package fsa_pkg:
  - channel state enum {EMPTY, FILL}.
  - Defaults for C_AVG_LOG2 and C_JITTER_TOL.
- Sub-module fsa_header_avg: one channel, containing accumulator, FSM, miss counters and publish logic. Instantiated twice (left, right).
- Top level: update OR and en gating only.

## Test plan
- Left X = 100, 102, 101, 103 on four sample events → after the 4th, lft_x=101 (406>>2), lft_valid=1, update pulses for one cycle. rt_valid stays 0.
- Left X = 100, 100, 110, 111, 109, 110 → 110 breaches tol 4 and restarts the batch. Publish happens after the 6th sample with lft_x=110 (440>>2).
- Right valid for 4 frames at X=500 (rt_x=500), then 4 invalid frames → rt_valid drops at the 4th miss, rt_x holds 500, rt_miss_cnt=4.
- 300 invalid left frames → lft_miss_cnt saturates at 255.
- en=0 during frame_done pulses → no state change. en toggled low mid-batch after 2 samples → the next 4 valid samples are required before publish.
- resetn pulsed low asynchronously (between clock edges) after 3 samples → all outputs 0 immediately. A fresh 4-sample batch is needed to publish.
